serial_receiver: RTL and testbench
==================================

SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter N, default 4: received word width in bits; legal values are N >= 2.
REQ-002 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port in, input, 1 bit: serial data bit, sent LSB first.
REQ-005 Port in_valid, input, 1 bit: when high, in is valid this cycle.
REQ-006 Port start, input, 1 bit: when high with in_valid, marks the first bit of a frame.
REQ-007 Port O, output, N bits: last completed received word.
REQ-008 Port o_valid, output, 1 bit: O holds an unconsumed word.
REQ-009 Port o_ready, input, 1 bit: the consumer accepts O this cycle.
REQ-010 Port busy, output, 1 bit: a frame is partially received.
REQ-011 Port overrun, output, 1 bit: sticky flag for a dropped word.

Function
REQ-012 Internal FSM has two states, IDLE and RECV, plus an N-bit shift register sr and a bit counter cnt of width clog2(N+1).
REQ-013 IDLE, in_valid=1 and start=1: load the bit per the shift rule (REQ-015), set cnt=1, go to RECV.
REQ-014 IDLE, in_valid=1 and start=0: ignore the bit; no state change.
REQ-015 RECV, in_valid=1 and start=0: sr <= {in, sr[N-1:1]} (shift right, new bit at MSB), then cnt <= cnt+1.
REQ-016 RECV, in_valid=0: sr, cnt and state hold (gaps of any length are allowed).
REQ-017 RECV, in_valid=1 and start=1: discard the partial frame, treat in as bit 0 of a new frame, set cnt=1, stay in RECV.
REQ-018 Completion is the edge at which the Nth bit is accepted (cnt=N-1 before the edge).
REQ-019 On completion, the word {in, sr[N-1:1]} is delivered to O per REQ-021..023, cnt clears, and the FSM returns to IDLE.
REQ-020 Latency: O and o_valid are updated at the same edge that accepts the Nth bit, so they are visible in the following cycle.
REQ-021 Completion with o_valid=0, or with o_valid=1 and o_ready=1: O <= new word, o_valid=1.
REQ-022 Completion with o_valid=1 and o_ready=0: the new word is dropped, O is unchanged, and overrun is set to 1.
REQ-023 No completion, with o_valid=1 and o_ready=1: o_valid clears at that edge; O keeps its value.
REQ-024 O is stable whenever o_valid=1, except on the simultaneous accept-and-complete case of REQ-021.
REQ-025 o_ready is ignored while o_valid=0.
REQ-026 busy = (state == RECV); it is registered state, not a combinational function of the inputs.
REQ-027 overrun stays at 1 until reset; no other event clears it.
REQ-028 Bit ordering mates with a right-shifting serializer: the first bit received lands in O[0] and the last in O[N-1].

Reset
REQ-029 reset_n=0 immediately forces: state=IDLE, sr=0, cnt=0, O=0, o_valid=0, busy=0, overrun=0, with no clock required.
REQ-030 Reset asserted mid-frame discards the partial frame; the first start after release begins a fresh frame.
REQ-031 While reset_n=0, all inputs are ignored; normal operation resumes at the first rising clk edge after release.

Verification (N=4)
REQ-032 Frame: start with bits 1,0,1,1 on consecutive cycles, o_ready=0 -> the cycle after the 4th bit shows O=4'b1101, o_valid=1, busy=0; busy=1 during bits 2-4.
REQ-033 Gaps: the same frame with in_valid=0 for 3 cycles between bits 2 and 3 -> O=4'b1101; busy holds 1 through the gap; o_valid is delayed by exactly 3 cycles.
REQ-034 Backpressure: word 4'hA pending with o_ready=0, then a second frame 4'h5 completes -> O=4'hA, overrun=1; after o_ready=1 for one cycle, o_valid=0 and overrun stays 1.
REQ-035 Simultaneous: word 4'h3 pending, o_ready=1 at the edge completing 4'hC -> O=4'hC, o_valid=1, overrun=0.
REQ-036 Resync: two bits received, then start with bits 0,1,1,0 -> O=4'b0110; the partial bits are lost.
REQ-037 Reset: reset_n pulsed low after the 3rd bit -> all outputs 0 at once; the next full frame 4'h9 yields O=4'h9.

Source files
------------

// File: rtl/serial_receiver.sv
// Serial-to-parallel receiver: LSB-first frames of N bits, one-word output
// buffer with valid/ready handshake and a sticky overrun flag.
//
// state | meaning
// IDLE  | waiting for a start bit; in_valid without start is ignored
// RECV  | frame in progress; cnt holds the number of bits accepted so far
module serial_receiver #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in,
    input  logic         in_valid,
    input  logic         start,
    output logic [N-1:0] O,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         busy,
    output logic         overrun
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  sr;
    logic [CW-1:0] cnt;
    logic [N-1:0]  word;
    logic          accept;
    logic          complete;

    // A start bit always restarts a frame, whether idle or mid-frame.
    assign accept   = in_valid && (start || (state == RECV));
    assign complete = in_valid && !start && (state == RECV) && (cnt == CNT_LAST);
    assign word     = {in, sr[N-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid && start) begin
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (complete) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RECV);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (accept) begin
            sr <= word;
            if (start) begin
                cnt <= CNT_ONE;
            end else if (complete) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // Output buffer: a completion while the previous word is still held and
    // not being consumed drops the new word and latches overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            O       <= '0;
            o_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (complete) begin
            if (!o_valid || o_ready) begin
                O       <= word;
                o_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (o_valid && o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver (N=4): framing, gaps, resync,
// backpressure/overrun, simultaneous accept-and-complete, async reset.
module tb_serial_receiver;

    localparam int N = 4;

    logic         clk;
    logic         reset_n;
    logic         in;
    logic         in_valid;
    logic         start;
    logic [N-1:0] O;
    logic         o_valid;
    logic         o_ready;
    logic         busy;
    logic         overrun;

    int n_cmp;
    int n_bad;

    serial_receiver #(.N(N)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in       (in),
        .in_valid (in_valid),
        .start    (start),
        .O        (O),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic st);
        in       = b;
        in_valid = 1'b1;
        start    = st;
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
        in       = 1'b0;
    endtask

    // Sends a full frame LSB first with no gaps.
    task automatic send_word(input logic [N-1:0] w);
        for (int i = 0; i < N; i++) begin
            send_bit(w[i], i == 0);
        end
    endtask

    task automatic consume();
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset_n  = 1'b0;
        in       = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        o_ready  = 1'b0;
        #12;
        check("rst_O", 32'(O), 32'h0);
        check("rst_o_valid", 32'(o_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        reset_n = 1'b1;
        tick();

        // Idle bit without start is ignored
        send_bit(1'b1, 1'b0);
        check("idle_ignore_busy", 32'(busy), 32'h0);

        // Basic frame 1,0,1,1
        send_bit(1'b1, 1'b1);
        check("f1_busy_b2", 32'(busy), 32'h1);
        send_bit(1'b0, 1'b0);
        check("f1_busy_b3", 32'(busy), 32'h1);
        send_bit(1'b1, 1'b0);
        check("f1_busy_b4", 32'(busy), 32'h1);
        check("f1_no_valid_yet", 32'(o_valid), 32'h0);
        send_bit(1'b1, 1'b0);
        check("f1_O", 32'(O), 32'hD);
        check("f1_o_valid", 32'(o_valid), 32'h1);
        check("f1_busy_done", 32'(busy), 32'h0);
        tick();
        check("f1_hold_O", 32'(O), 32'hD);
        check("f1_hold_valid", 32'(o_valid), 32'h1);
        consume();
        check("f1_consumed", 32'(o_valid), 32'h0);
        check("f1_O_kept", 32'(O), 32'hD);

        // Same frame with a 3-cycle gap between bits 2 and 3
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tick();
            check("gap_busy", 32'(busy), 32'h1);
            check("gap_no_valid", 32'(o_valid), 32'h0);
        end
        send_bit(1'b1, 1'b0);
        check("gap_valid_late", 32'(o_valid), 32'h0);
        send_bit(1'b1, 1'b0);
        check("gap_O", 32'(O), 32'hD);
        check("gap_o_valid", 32'(o_valid), 32'h1);
        consume();

        // Simultaneous accept-and-complete: 3 pending, C completes with o_ready=1
        send_word(4'h3);
        check("sim_first_O", 32'(O), 32'h3);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("sim_still_3", 32'(O), 32'h3);
        o_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        o_ready = 1'b0;
        check("sim_O", 32'(O), 32'hC);
        check("sim_o_valid", 32'(o_valid), 32'h1);
        check("sim_overrun", 32'(overrun), 32'h0);
        consume();

        // Resync: two bits, then a new start with 0,1,1,0
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        check("resync_busy", 32'(busy), 32'h1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("resync_not_early", 32'(o_valid), 32'h0);
        send_bit(1'b0, 1'b0);
        check("resync_O", 32'(O), 32'h6);
        check("resync_o_valid", 32'(o_valid), 32'h1);
        consume();

        // Backpressure: A pending, 5 dropped, overrun sticky
        send_word(4'hA);
        check("bp_first_O", 32'(O), 32'hA);
        send_word(4'h5);
        check("bp_O_kept", 32'(O), 32'hA);
        check("bp_overrun", 32'(overrun), 32'h1);
        check("bp_o_valid", 32'(o_valid), 32'h1);
        consume();
        check("bp_consumed", 32'(o_valid), 32'h0);
        check("bp_overrun_sticky", 32'(overrun), 32'h1);
        check("bp_O_after", 32'(O), 32'hA);

        // Async reset after the 3rd bit of a frame
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        reset_n = 1'b0;
        #2;
        check("arst_O", 32'(O), 32'h0);
        check("arst_o_valid", 32'(o_valid), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_overrun", 32'(overrun), 32'h0);
        in       = 1'b1;
        in_valid = 1'b1;
        start    = 1'b1;
        tick();
        check("arst_ignores_in", 32'(busy), 32'h0);
        in_valid = 1'b0;
        start    = 1'b0;
        in       = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        // A stale 4th bit must not complete anything
        send_bit(1'b1, 1'b0);
        check("arst_no_complete", 32'(o_valid), 32'h0);
        send_word(4'h9);
        check("arst_O9", 32'(O), 32'h9);
        check("arst_valid9", 32'(o_valid), 32'h1);
        check("arst_overrun9", 32'(overrun), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
